// File: rtl/period_meter_pkg.sv
// period_meter_pkg
//   Shared definitions for the period meter slice.
//   Holds the FSM state encoding used by period_meter. The states are plain
//   localparam constants so that older blocks which compare raw state codes
//   keep working unchanged.
package period_meter_pkg;

    localparam logic [1:0] IDLE = 2'd0;  // disabled, everything cleared
    localparam logic [1:0] SEEK = 2'd1;  // waiting for the first rising edge
    localparam logic [1:0] MEAS = 2'd2;  // counting between rising edges

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
//   Brings an asynchronous level into the clk domain and produces one-cycle
//   rise/fall strobes. The strobes are registered, so both edges see the same
//   latency of SYNC_STAGES+1 cycles from sig_in.
// Ports
//   clk     in   system clock, rising edge
//   reset   in   synchronous, active-high reset
//   clear   in   synchronous clear of all flops (block disabled)
//   sig_in  in   asynchronous input level
//   rise    out  one-cycle strobe on a 0->1 transition of the synchronized level
//   fall    out  one-cycle strobe on a 1->0 transition of the synchronized level
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no latch is inferred; flops use non-blocking '<='.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
        if (clear) begin
            sync_d = '0;
            prev_d = 1'b0;
            rise_d = 1'b0;
            fall_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/period_meter.sv
// period_meter
//   Measures a slow square wave in clk cycles: period (rise to rise) and high
//   time (rise to following fall), delivered through a valid/ready handshake.
//   Back-to-back: the rise that closes one period opens the next one.
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   enable      in   0 = idle, outputs and sticky flags cleared; 1 = measure
//   sig_in      in   signal under test, asynchronous to clk
//   meas_ready  in   consumer takes the result when meas_valid && meas_ready
//   meas_valid  out  period/high_time hold an unconsumed measurement
//   period      out  clk cycles between consecutive rising edges
//   high_time   out  clk cycles from a rise to the following fall (0 if none)
//   timeout     out  sticky: no rising edge within TIMEOUT cycles
//   overrun     out  sticky: a result completed while the previous was unconsumed
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             timeout,
    output logic             overrun
);

    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

    logic rise, fall;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .clear (~enable),
        .sig_in(sig_in),
        .rise  (rise),
        .fall  (fall)
    );

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_cap_q, hi_cap_d;    // high time of the open period
    logic             fell_q, fell_d;        // a fall was seen in the open period
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;
    logic             complete;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_cap_d  = hi_cap_q;
        fell_d    = fell_q;
        valid_d   = valid_q;
        period_d  = period_q;
        high_d    = high_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q;
        complete  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SEEK;
                    cnt_d   = WIDTH'(1);
                end
            end
            SEEK: begin
                if (rise) begin
                    state_d = MEAS;
                    cnt_d   = WIDTH'(1);
                    fell_d  = 1'b0;
                end else if (cnt_q == TIMEOUT_W) begin
                    timeout_d = 1'b1;
                    cnt_d     = WIDTH'(1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MEAS: begin
                // A rise both closes the current period and opens the next.
                if (rise) begin
                    complete = 1'b1;
                    cnt_d    = WIDTH'(1);
                    fell_d   = 1'b0;
                end else if (cnt_q == TIMEOUT_W) begin
                    timeout_d = 1'b1;
                    state_d   = SEEK;
                    cnt_d     = WIDTH'(1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (fall) begin
                        hi_cap_d = cnt_q;
                        fell_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (valid_q && meas_ready) begin
            valid_d = 1'b0;
        end

        // The result slot is free if empty or being drained this very cycle;
        // otherwise the new result is dropped and the old one kept.
        if (complete) begin
            timeout_d = 1'b0;
            if (!valid_q || meas_ready) begin
                valid_d  = 1'b1;
                period_d = cnt_q;
                high_d   = fell_q ? hi_cap_q : '0;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (!enable) begin
            state_d   = IDLE;
            cnt_d     = '0;
            hi_cap_d  = '0;
            fell_d    = 1'b0;
            valid_d   = 1'b0;
            period_d  = '0;
            high_d    = '0;
            timeout_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_cap_q  <= '0;
            fell_q    <= 1'b0;
            valid_q   <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_cap_q  <= hi_cap_d;
            fell_q    <= fell_d;
            valid_q   <= valid_d;
            period_q  <= period_d;
            high_q    <= high_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign meas_valid = valid_q;
    assign period     = period_q;
    assign high_time  = high_q;
    assign timeout    = timeout_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter
//   Self-checking bench for period_meter. Waveforms are built as lists of
//   (high, low) pulse lengths; the expected results follow directly from
//   those lengths: each pulse that is followed by another rise yields
//   period = high + low and high_time = high.
module tb_period_meter;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 50;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             sig_in = 1'b0;
    logic             meas_ready = 1'b1;
    logic             meas_valid;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             timeout;
    logic             overrun;

    int n_checks = 0;
    int n_fail   = 0;

    period_meter #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(2),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .sig_in    (sig_in),
        .meas_ready(meas_ready),
        .meas_valid(meas_valid),
        .period    (period),
        .high_time (high_time),
        .timeout   (timeout),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive a constant level on sig_in for a number of cycles.
    task automatic drive(input bit v, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1 sig_in = v;
        end
    endtask

    // Disable, let everything clear, then enable with sig_in low.
    task automatic restart();
        @(posedge clk);
        #1 enable = 1'b0;
        sig_in     = 1'b0;
        meas_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 enable = 1'b1;
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if (meas_valid !== 1'b0 || period !== '0 || high_time !== '0 ||
            timeout !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: valid=%b period=%0d high=%0d timeout=%b overrun=%b, required all 0",
                     name, meas_valid, period, high_time, timeout, overrun);
        end
    endtask

    // Play n pulses with meas_ready=1 and compare every accepted result
    // against the list derived from the pulse lengths.
    task automatic run_pulses(input string name, input int n, input int h_fix,
                              input int l_fix, input bit rnd);
        bit wave[$];
        int exp_p[$];
        int exp_h[$];
        int h, l, p_e, h_e;
        meas_ready = 1'b1;
        repeat (4) wave.push_back(1'b0);
        for (int k = 0; k < n; k++) begin
            h = rnd ? int'($urandom_range(1, 15)) : h_fix;
            l = rnd ? int'($urandom_range(1, 15)) : l_fix;
            repeat (h) wave.push_back(1'b1);
            repeat (l) wave.push_back(1'b0);
            if (k < n - 1) begin
                exp_p.push_back(h + l);
                exp_h.push_back(h);
            end
        end
        repeat (8) wave.push_back(1'b0);

        for (int i = 0; i < wave.size(); i++) begin
            @(posedge clk);
            #1 sig_in = wave[i];
            @(negedge clk);
            if (meas_valid && meas_ready) begin
                n_checks++;
                if (exp_p.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s: unexpected result period=%0d high=%0d, required none",
                             name, period, high_time);
                end else begin
                    p_e = exp_p.pop_front();
                    h_e = exp_h.pop_front();
                    if (period !== WIDTH'(p_e) || high_time !== WIDTH'(h_e) ||
                        timeout !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s: got period=%0d high=%0d timeout=%b, required period=%0d high=%0d timeout=0",
                                 name, period, high_time, timeout, p_e, h_e);
                    end
                end
            end
        end

        n_checks++;
        if (exp_p.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d results missing, required 0", name, exp_p.size());
        end
        n_checks++;
        if (timeout !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL %s flags: timeout=%b overrun=%b, required 0 0", name, timeout, overrun);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 sig_in = i[0];
        end
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        sig_in = 1'b0;
    endtask

    task automatic test_basic();
        restart();
        run_pulses("period10_high5", 6, 5, 5, 1'b0);
    endtask

    task automatic test_div3();
        restart();
        run_pulses("div3", 8, 2, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        restart();
        run_pulses("toggle", 12, 1, 1, 1'b0);
    endtask

    task automatic test_random();
        restart();
        run_pulses("random", 14, 0, 0, 1'b1);
    endtask

    task automatic test_overrun();
        restart();
        meas_ready = 1'b0;
        drive(1'b0, 4);
        drive(1'b1, 3);
        drive(1'b0, 5);
        drive(1'b1, 5);
        drive(1'b0, 3);
        drive(1'b1, 4);
        drive(1'b0, 6);
        @(negedge clk);
        n_checks++;
        if (meas_valid !== 1'b1 || period !== WIDTH'(8) || high_time !== WIDTH'(3) ||
            overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_hold: valid=%b period=%0d high=%0d overrun=%b, required 1 8 3 1",
                     meas_valid, period, high_time, overrun);
        end
        @(posedge clk);
        #1 meas_ready = 1'b1;
        @(posedge clk);
        #1 meas_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (meas_valid !== 1'b0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_drain: valid=%b overrun=%b, required 0 1", meas_valid, overrun);
        end
    endtask

    task automatic test_timeout();
        int first;
        first = -1;
        restart();
        // The edge that samples enable=1 is edge 1; the counter then needs
        // TIMEOUT more edges to reach and act on TIMEOUT.
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (timeout === 1'b1 && first < 0) first = k;
        end
        n_checks++;
        if (first != TIMEOUT + 1) begin
            n_fail++;
            $display("FAIL timeout_time: timeout first seen at edge %0d, required %0d",
                     first, TIMEOUT + 1);
        end
        run_pulses("timeout_recover", 3, 10, 10, 1'b0);
    endtask

    task automatic test_reset_and_disable();
        restart();
        meas_ready = 1'b0;
        drive(1'b0, 4);
        drive(1'b1, 4);
        drive(1'b0, 4);
        drive(1'b1, 4);
        drive(1'b0, 4);
        drive(1'b1, 2);
        @(negedge clk);
        n_checks++;
        if (meas_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_valid: valid=%b, required 1", meas_valid);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        sig_in = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset_mid_meas");
        run_pulses("after_reset", 3, 4, 4, 1'b0);

        meas_ready = 1'b0;
        drive(1'b1, 3);
        drive(1'b0, 3);
        drive(1'b1, 3);
        drive(1'b0, 3);
        drive(1'b1, 2);
        @(posedge clk);
        #1 enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("disable_mid_meas");
        #1 sig_in = 1'b0;
        @(posedge clk);
        #1 enable = 1'b1;
        run_pulses("after_disable", 3, 6, 3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div3();
        test_back_to_back();
        test_random();
        test_overrun();
        test_timeout();
        test_reset_and_disable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
